csr_access_seq: RTL

// Initiator side of the CSR unit interface. Accepts one decoded CSR/system instruction from EXU.

---
 rtl/csr_access_seq_pkg.sv | 54 +++++
 rtl/csr_access_seq_alu.sv | 48 ++++
 rtl/csr_access_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/csr_access_seq_pkg.sv
// ----------------------------------------------------------------------------
// csr_access_seq_pkg
// Shared definitions for the CSR access sequencer and its ALU:
//   - instruction kind codes coming from EXU
//   - Zicsr funct3 encodings
//   - csr_ctrl command codes (identical to the CSRU's decoding)
//   - sequencer FSM state enum
//   - machine-mode CSR addresses used by the trap path
// ----------------------------------------------------------------------------
package csr_access_seq_pkg;

  typedef enum logic [1:0] {
    KIND_CSR    = 2'b00,
    KIND_ECALL  = 2'b01,
    KIND_MRET   = 2'b10,
    KIND_EBREAK = 2'b11
  } kind_e;

  // funct3[2] selects the immediate form, funct3[1:0] selects the operation.
  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [2:0] CTRL_NONE   = 3'b000;
  localparam logic [2:0] CTRL_MRET   = 3'b001;
  localparam logic [2:0] CTRL_ECALL  = 3'b010;
  localparam logic [2:0] CTRL_EBREAK = 3'b011;
  localparam logic [2:0] CTRL_CSRW   = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_RESP  = 2'b11
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // funct3 values 000 and 100 carry no Zicsr operation.
  function automatic logic f3_illegal(input logic [2:0] funct3);
    return funct3[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/csr_access_seq_alu.sv
// ----------------------------------------------------------------------------
// csr_access_seq_alu
// Combinational Zicsr result unit.
//   op              in   2     funct3[1:0]: 01 write, 10 set, 11 clear
//   old_val         in   XLEN  current CSR value
//   operand         in   XLEN  rs1 value or zero-extended immediate
//   operand_nonzero in   1     source is architecturally nonzero
//   new_val         out  XLEN  value to write back
//   write_needed    out  1     write-back must be issued
// Set/clear forms only write when their source is nonzero; the decision
// depends on the source alone, never on whether the CSR value changes.
// ----------------------------------------------------------------------------
module csr_access_seq_alu
  import csr_access_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  input  logic            operand_nonzero,
  output logic [XLEN-1:0] new_val,
  output logic            write_needed
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    new_val      = old_val;
    write_needed = 1'b0;
    case (op)
      OP_RW: begin
        new_val      = operand;
        write_needed = 1'b1;
      end
      OP_RS: begin
        new_val      = old_val | operand;
        write_needed = operand_nonzero;
      end
      OP_RC: begin
        new_val      = old_val & ~operand;
        write_needed = operand_nonzero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_access_seq.sv
// ----------------------------------------------------------------------------
// csr_access_seq
// Initiator side of the CSR unit interface. Accepts one decoded CSR/system
// instruction from EXU, reads the old CSR value, writes back the Zicsr result
// (or the ECALL trap state) and returns old value / redirect target to WBU.
// One instruction in flight: IDLE -> READ -> [WRITE] -> RESP -> IDLE.
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   in_valid/in_ready, in_*        EXU request (in_ready high only in IDLE)
//   csr_valid/wen/ctrl/raddr/
//   waddr/wdata/pc                 CSRU command (valid/wen only in WRITE)
//   csr_rdata, csr_upc             CSRU combinational read data / target
//   out_valid/out_ready, out_*     WBU response, held until accepted
// ----------------------------------------------------------------------------
module csr_access_seq
  import csr_access_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic [CSR_AW-1:0] in_csr,
  input  logic [XLEN-1:0]   in_src,
  input  logic [4:0]        in_zimm,
  input  logic              in_src_zero,
  input  logic [XLEN-1:0]   in_pc,
  output logic              csr_valid,
  output logic              csr_wen,
  output logic [2:0]        csr_ctrl,
  output logic [CSR_AW-1:0] csr_raddr,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic [XLEN-1:0]   csr_pc,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic [XLEN-1:0]   csr_upc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_jump,
  output logic [XLEN-1:0]   out_dnpc,
  output logic              out_ebreak,
  output logic              out_illegal
);

  state_e            state;
  kind_e             kind_q;
  logic [2:0]        funct3_q;
  logic [CSR_AW-1:0] csr_q;
  logic [XLEN-1:0]   src_q;
  logic [4:0]        zimm_q;
  logic              src_zero_q;
  logic [XLEN-1:0]   pc_q;

  logic [XLEN-1:0]   operand;
  logic              operand_nonzero;
  logic [XLEN-1:0]   new_val;
  logic              alu_write;
  logic              is_csr_op;
  logic              illegal;
  logic              is_jump;
  logic              do_write;

  // Immediate forms use the zero-extended zimm and judge "nonzero" on it;
  // register forms rely on the rs1==x0 flag from decode.
  assign operand         = funct3_q[2] ? {{(XLEN-5){1'b0}}, zimm_q} : src_q;
  assign operand_nonzero = funct3_q[2] ? (zimm_q != 5'd0) : !src_zero_q;

  assign is_csr_op = (kind_q == KIND_CSR);
  assign illegal   = is_csr_op && f3_illegal(funct3_q);
  assign is_jump   = (kind_q == KIND_ECALL) || (kind_q == KIND_MRET);
  assign do_write  = (is_csr_op && alu_write) || (kind_q == KIND_ECALL);

  csr_access_seq_alu #(.XLEN(XLEN)) u_alu (
    .op              (funct3_q[1:0]),
    .old_val         (csr_rdata),
    .operand         (operand),
    .operand_nonzero (operand_nonzero),
    .new_val         (new_val),
    .write_needed    (alu_write)
  );

  // NOTE: all state and registered outputs update with non-blocking
  // assignments so every flop samples pre-edge values, independent of order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      kind_q      <= KIND_CSR;
      funct3_q    <= '0;
      csr_q       <= '0;
      src_q       <= '0;
      zimm_q      <= '0;
      src_zero_q  <= 1'b0;
      pc_q        <= '0;
      in_ready    <= 1'b1;
      csr_valid   <= 1'b0;
      csr_wen     <= 1'b0;
      csr_ctrl    <= CTRL_NONE;
      csr_raddr   <= '0;
      csr_waddr   <= '0;
      csr_wdata   <= '0;
      csr_pc      <= '0;
      out_valid   <= 1'b0;
      out_rdata   <= '0;
      out_jump    <= 1'b0;
      out_dnpc    <= '0;
      out_ebreak  <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            kind_q     <= kind_e'(in_kind);
            funct3_q   <= in_funct3;
            csr_q      <= in_csr;
            src_q      <= in_src;
            zimm_q     <= in_zimm;
            src_zero_q <= in_src_zero;
            pc_q       <= in_pc;
            in_ready   <= 1'b0;
            // Address and ctrl are presented during READ so the CSRU's
            // combinational rdata/upc are valid on that cycle.
            csr_raddr  <= in_csr;
            if (kind_e'(in_kind) == KIND_ECALL)     csr_ctrl <= CTRL_ECALL;
            else if (kind_e'(in_kind) == KIND_MRET) csr_ctrl <= CTRL_MRET;
            else                                    csr_ctrl <= CTRL_NONE;
            state      <= S_READ;
          end
        end
        S_READ: begin
          out_rdata   <= (is_csr_op && !illegal) ? csr_rdata : '0;
          out_jump    <= is_jump;
          out_dnpc    <= is_jump ? csr_upc : '0;
          out_ebreak  <= (kind_q == KIND_EBREAK);
          out_illegal <= illegal;
          if (do_write) begin
            csr_valid <= 1'b1;
            csr_wen   <= 1'b1;
            csr_ctrl  <= (kind_q == KIND_ECALL) ? CTRL_ECALL : CTRL_CSRW;
            csr_waddr <= csr_q;
            csr_wdata <= is_csr_op ? new_val : '0;
            csr_pc    <= pc_q;
            state     <= S_WRITE;
          end else begin
            csr_ctrl  <= CTRL_NONE;
            out_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_WRITE: begin
          csr_valid <= 1'b0;
          csr_wen   <= 1'b0;
          csr_ctrl  <= CTRL_NONE;
          out_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
